// File: rtl/count_rtl_pkg.sv
// Shared types and default sizing for the count_core_snap counter slice.
//   DEF_WIDTH / DEF_MOD : default counter width and modulus
//   TS_WIDTH            : width of the optional snapshot timestamp
//   snap_state_e        : snapshot buffer states
package count_rtl_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_MOD   = 12;
    localparam int unsigned TS_WIDTH  = 16;

    typedef enum logic {
        SNAP_IDLE = 1'b0,
        SNAP_HOLD = 1'b1
    } snap_state_e;

endpackage

// File: rtl/count_snap_buf.sv
// One-entry snapshot buffer with a valid/ready read-out.
// Build option: COUNT_SNAP_TS_EN adds a free-running 16-bit cycle counter
// that is captured into snap_ts alongside snap_data.
//   clock, reset            : clock, async active-high reset
//   snap_req                : capture request (samples count)
//   snap_ready              : reader accepts the held snapshot
//   clr_flags               : clears snap_ovr (a coincident set wins)
//   count                   : live count value to capture
//   snap_valid/snap_data    : held snapshot
//   snap_ts                 : captured timestamp (COUNT_SNAP_TS_EN only)
//   snap_ovr                : sticky, a request was dropped while full
module count_snap_buf
    import count_rtl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                snap_req,
    input  logic                snap_ready,
    input  logic                clr_flags,
    input  logic [WIDTH-1:0]    count,
    output logic                snap_valid,
    output logic [WIDTH-1:0]    snap_data,
`ifdef COUNT_SNAP_TS_EN
    output logic [TS_WIDTH-1:0] snap_ts,
`endif
    output logic                snap_ovr
);

    snap_state_e      r_state;
    snap_state_e      w_state_next;
    logic             w_capture;
    logic             w_ovr_set;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_ovr;

    // Next-state decode: accept with a new request recaptures without a bubble
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_ovr_set    = 1'b0;
        case (r_state)
            SNAP_IDLE: begin
                if (snap_req) begin
                    w_capture    = 1'b1;
                    w_state_next = SNAP_HOLD;
                end
            end
            SNAP_HOLD: begin
                if (snap_ready) begin
                    if (snap_req) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_next = SNAP_IDLE;
                    end
                end else if (snap_req) begin
                    w_ovr_set = 1'b1;
                end
            end
            default: w_state_next = SNAP_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= SNAP_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Holding register and overrun flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_valid <= (w_state_next == SNAP_HOLD);
            if (w_capture) begin
                r_data <= count;
            end
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (clr_flags) begin
                r_ovr <= 1'b0;
            end
        end
    end

`ifdef COUNT_SNAP_TS_EN
    logic [TS_WIDTH-1:0] r_ts_cnt;
    logic [TS_WIDTH-1:0] r_ts;

    // Free-running cycle counter, wraps naturally at all-ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ts_cnt <= '0;
            r_ts     <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + TS_WIDTH'(1);
            if (w_capture) begin
                r_ts <= r_ts_cnt;
            end
        end
    end

    assign snap_ts = r_ts;
`endif

    assign snap_valid = r_valid;
    assign snap_data  = r_data;
    assign snap_ovr   = r_ovr;

endmodule

// File: rtl/count_core_snap.sv
// Loadable up/down modulo-MOD counter with wrap flags and a snapshot port.
// Build option: COUNT_SNAP_TS_EN adds the snap_ts output.
//   clock, reset          : clock, async active-high reset
//   load, data_in         : load (clamped to MOD-1), highest priority
//   en, up_down           : count enable and direction (1 = up)
//   clr_flags             : clears wrap_sticky and snap_ovr
//   data_out              : registered count
//   tc                    : combinational terminal count (wrap next edge)
//   wrap, wrap_sticky     : one-cycle wrap pulse and its sticky copy
//   snap_req/valid/ready  : snapshot handshake, snap_data holds the value
//   snap_ts               : snapshot timestamp (COUNT_SNAP_TS_EN only)
//   snap_ovr              : sticky dropped-request flag
module count_core_snap
    import count_rtl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned MOD   = DEF_MOD
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [WIDTH-1:0]    data_in,
    input  logic                en,
    input  logic                up_down,
    input  logic                clr_flags,
    output logic [WIDTH-1:0]    data_out,
    output logic                tc,
    output logic                wrap,
    output logic                wrap_sticky,
    input  logic                snap_req,
    output logic                snap_valid,
    input  logic                snap_ready,
    output logic [WIDTH-1:0]    snap_data,
`ifdef COUNT_SNAP_TS_EN
    output logic [TS_WIDTH-1:0] snap_ts,
`endif
    output logic                snap_ovr
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic             w_wrap_next;
    logic             w_at_max;
    logic             w_at_zero;
    logic             r_wrap;
    logic             r_wrap_sticky;

    assign w_at_max  = (r_count == MAX_VAL);
    assign w_at_zero = (r_count == '0);

    // Counter next value: load > en > hold
    always_comb begin
        w_count_next = r_count;
        w_wrap_next  = 1'b0;
        if (load) begin
            w_count_next = (data_in > MAX_VAL) ? MAX_VAL : data_in;
        end else if (en) begin
            if (up_down) begin
                if (w_at_max) begin
                    w_count_next = '0;
                    w_wrap_next  = 1'b1;
                end else begin
                    w_count_next = r_count + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
                    w_count_next = MAX_VAL;
                    w_wrap_next  = 1'b1;
                end else begin
                    w_count_next = r_count - WIDTH'(1);
                end
            end
        end
    end

    // Count and wrap flags; a wrap on the clearing edge keeps the flag set
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count       <= '0;
            r_wrap        <= 1'b0;
            r_wrap_sticky <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_wrap  <= w_wrap_next;
            if (w_wrap_next) begin
                r_wrap_sticky <= 1'b1;
            end else if (clr_flags) begin
                r_wrap_sticky <= 1'b0;
            end
        end
    end

    assign data_out    = r_count;
    assign wrap        = r_wrap;
    assign wrap_sticky = r_wrap_sticky;
    assign tc          = en & ((up_down & w_at_max) | (~up_down & w_at_zero));

    // Snapshot captures the pre-update count
    count_snap_buf #(
        .WIDTH(WIDTH)
    ) u_snap_buf (
        .clock      (clock),
        .reset      (reset),
        .snap_req   (snap_req),
        .snap_ready (snap_ready),
        .clr_flags  (clr_flags),
        .count      (r_count),
        .snap_valid (snap_valid),
        .snap_data  (snap_data),
`ifdef COUNT_SNAP_TS_EN
        .snap_ts    (snap_ts),
`endif
        .snap_ovr   (snap_ovr)
    );

endmodule

// File: tb/tb_count_core_snap.sv
// Scoreboard bench for count_core_snap (WIDTH=4, MOD=12).
module tb_count_core_snap;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] data_in;
    logic       en;
    logic       up_down;
    logic       clr_flags;
    logic [3:0] data_out;
    logic       tc;
    logic       wrap;
    logic       wrap_sticky;
    logic       snap_req;
    logic       snap_valid;
    logic       snap_ready;
    logic [3:0] snap_data;
    logic       snap_ovr;
`ifdef COUNT_SNAP_TS_EN
    logic [15:0] snap_ts;
`endif

    typedef struct {
        int         idx;
        logic [3:0] d;
        logic       tc;
        logic       wr;
        logic       ws;
        logic       sv;
        logic [3:0] sd;
        logic       ovr;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_items  = 0;

    count_core_snap #(.WIDTH(4), .MOD(12)) dut (
        .clock       (clk),
        .reset       (reset),
        .load        (load),
        .data_in     (data_in),
        .en          (en),
        .up_down     (up_down),
        .clr_flags   (clr_flags),
        .data_out    (data_out),
        .tc          (tc),
        .wrap        (wrap),
        .wrap_sticky (wrap_sticky),
        .snap_req    (snap_req),
        .snap_valid  (snap_valid),
        .snap_ready  (snap_ready),
        .snap_data   (snap_data),
`ifdef COUNT_SNAP_TS_EN
        .snap_ts     (snap_ts),
`endif
        .snap_ovr    (snap_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Drive one cycle of inputs and queue the state expected after the edge
    task automatic step(input logic ld, input logic [3:0] din, input logic e,
                        input logic ud, input logic cl, input logic rq,
                        input logic rd, input logic [3:0] x_d, input logic x_tc,
                        input logic x_wr, input logic x_ws, input logic x_sv,
                        input logic [3:0] x_sd, input logic x_ovr);
        exp_t x;
        @(negedge clk);
        load = ld; data_in = din; en = e; up_down = ud;
        clr_flags = cl; snap_req = rq; snap_ready = rd;
        x.idx = n_items; x.d = x_d; x.tc = x_tc; x.wr = x_wr; x.ws = x_ws;
        x.sv = x_sv; x.sd = x_sd; x.ovr = x_ovr;
        q.push_back(x);
        n_items++;
    endtask

    task automatic idle_inputs();
        load = 0; data_in = 0; en = 0; up_down = 0;
        clr_flags = 0; snap_req = 0; snap_ready = 0;
    endtask

    // Monitor: compare the DUT outputs presented after each active edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk($sformatf("item%0d data_out", x.idx), int'(data_out), int'(x.d));
                chk($sformatf("item%0d tc", x.idx), int'(tc), int'(x.tc));
                chk($sformatf("item%0d wrap", x.idx), int'(wrap), int'(x.wr));
                chk($sformatf("item%0d wrap_sticky", x.idx), int'(wrap_sticky), int'(x.ws));
                chk($sformatf("item%0d snap_valid", x.idx), int'(snap_valid), int'(x.sv));
                chk($sformatf("item%0d snap_data", x.idx), int'(snap_data), int'(x.sd));
                chk($sformatf("item%0d snap_ovr", x.idx), int'(snap_ovr), int'(x.ovr));
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        #2;
        chk("reset data_out", int'(data_out), 0);
        chk("reset snap_valid", int'(snap_valid), 0);
        chk("reset wrap_sticky", int'(wrap_sticky), 0);
        chk("reset snap_ovr", int'(snap_ovr), 0);
        @(negedge clk);
        reset = 1'b0;

        //    ld din en ud cl rq rd | d  tc wr ws sv sd ovr
        step(1, 3, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0,   4, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 1, 0,   5, 0, 0, 0, 1, 4, 0);

        // Asynchronous reset between edges
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        #1;
        chk("async reset data_out", int'(data_out), 0);
        chk("async reset snap_valid", int'(snap_valid), 0);
        chk("async reset snap_data", int'(snap_data), 0);
        @(negedge clk);
        reset = 1'b0;

        // Up wrap
        step(1, 10, 0, 0, 0, 0, 0,  10, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0,   11, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0);
        // Load beats enable, down wrap, clamps
        step(1, 0, 1, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0,   11, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0,   11, 0, 0, 0, 0, 0, 0);
        step(1, 14, 0, 0, 0, 0, 0,  11, 0, 0, 0, 0, 0, 0);
        step(1, 15, 1, 1, 0, 0, 0,  11, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 0, 0,   0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        // Back-pressured snapshot and overrun
        step(1, 7, 0, 0, 0, 0, 0,   7, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0,   7, 0, 0, 0, 1, 7, 0);
        step(0, 0, 0, 0, 0, 0, 0,   7, 0, 0, 0, 1, 7, 0);
        step(0, 0, 0, 0, 0, 0, 0,   7, 0, 0, 0, 1, 7, 0);
        step(0, 0, 0, 0, 0, 0, 0,   7, 0, 0, 0, 1, 7, 0);
        step(1, 2, 0, 0, 0, 1, 0,   2, 0, 0, 0, 1, 7, 1);
        step(0, 0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 0, 7, 1);
        step(0, 0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 0, 7, 1);
        step(0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 0, 0, 7, 0);
        // Back-to-back snapshots while counting
        step(1, 3, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 7, 0);
        step(0, 0, 1, 1, 0, 1, 1,   4, 0, 0, 0, 1, 3, 0);
        step(0, 0, 1, 1, 0, 1, 1,   5, 0, 0, 0, 1, 4, 0);
        step(0, 0, 1, 1, 0, 1, 1,   6, 0, 0, 0, 1, 5, 0);
        step(0, 0, 0, 0, 0, 0, 1,   6, 0, 0, 0, 0, 5, 0);
        // Overrun set coinciding with clear
        step(0, 0, 0, 0, 0, 1, 0,   6, 0, 0, 0, 1, 6, 0);
        step(0, 0, 0, 0, 1, 1, 0,   6, 0, 0, 0, 1, 6, 1);
        step(0, 0, 0, 0, 0, 0, 1,   6, 0, 0, 0, 0, 6, 1);
        step(0, 0, 0, 0, 1, 0, 0,   6, 0, 0, 0, 0, 6, 0);

        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) chk("scoreboard drain", q.size(), 0);

`ifdef COUNT_SNAP_TS_EN
        // Snapshot taken with 20 edges elapsed since reset release
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        chk("ts snap_valid", int'(snap_valid), 1);
        chk("ts snap_ts", int'(snap_ts), 20);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
